alu_mdu_seq: RTL
================

Name: alu_mdu_seq

Overview:
- Parametrised, handshaked successor to the core's combinational integer ALU.
- Executes the RV32I ALU ops with a registered result (latency 1).
- Adds RV32M multiply/divide through an iterative multi-cycle datapath.
- Sits in the execute stage; the pipeline stalls on `in_ready` / `out_valid`.

Parameters:
- XLEN, 32: datapath width; must be a power of 2, ≥ 8.
- MUL_BITS, 1: multiplier bits retired per CALC cycle (1, 2 or 4); must divide XLEN.
- SHAMT_W, $clog2(XLEN): shift-amount width (derived; do not override).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept an op
- r_type  in  1  R-type instruction
- i_type  in  1  I-type instruction
- b_type  in  1  branch instruction
- funct3  in  3  instruction funct3
- funct7  in  7  instruction funct7
- op_consShf  in  1  immediate shift (funct7[5] is significant)
- sub_sign_extEn  in  1  sign-extend operands into the SUB carry bit
- A  in  XLEN  operand A
- B  in  XLEN  operand B
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  XLEN  result
- flag  out  1  carry/borrow bit (base ops); divide-by-zero indicator (M ops)
- busy  out  1  state != IDLE

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - state = IDLE.
  - out_valid = 0, out = 0, flag = 0, busy = 0, in_ready = 1.
  - Any in-flight op is discarded; no result is ever presented for it.
- Accept: occurs on an edge with in_valid && in_ready. Operands and decode are latched; inputs are don't-care afterwards.
- in_ready = (state == IDLE). The block holds no second entry and does not overlap ops.
- M-op decode: r_type && funct7 == 7'b0000001. funct3 selects:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Base-op decode: key = {funct3, funct7[5]} when r_type | op_consShf | b_type, else {funct3, 0}.
  - 0000 ADD: result = {0,A}+{0,B}; flag = bit XLEN.
  - 0001 SUB: ext = sub_sign_extEn ? MSB : 0; result = {extA,A} − {extB,B}; flag = bit XLEN.
  - 0010 SLL, 1010 SRL, 1011 SRA: shift by B[SHAMT_W-1:0].
  - 0100 SLT: signed compare. 0110 SLTU: unsigned compare.
  - 1000 XOR, 1100 OR, 1110 AND.
  - Any other key: result = 0, flag = 0.
  - Base ops other than ADD/SUB: flag = 0.
- States:
  - IDLE: on accept of a base op → DONE with the result registered (out_valid rises the cycle after accept). On accept of an M op → CALC with iteration counter = 0.
  - CALC, multiply: MUL_BITS partial products per cycle over 2·XLEN-bit magnitudes; XLEN/MUL_BITS cycles.
    - Signed operands are converted to magnitudes and the sign is fixed up at the end.
    - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
  - CALC, divide: restoring division, 1 bit per cycle, XLEN cycles, on magnitudes.
    - Quotient sign = sA ^ sB. Remainder sign = sA.
  - CALC exit: when counter reaches its last iteration → DONE. out_valid asserts exactly N+1 cycles after accept, where N = iteration count.
  - DONE: out_valid = 1; out/flag held stable while out_ready = 0. On out_ready → IDLE; out_valid drops the next cycle. A new accept is possible on the following cycle.
- Divide boundary cases (bypass CALC, go straight to DONE, latency 1):
  - B == 0: DIV/DIVU quotient = all ones; REM/REMU = A; flag = 1.
  - DIV/REM with A == signed min and B == −1: quotient = signed min, remainder = 0, flag = 0.
- M ops other than divide-by-zero: flag = 0.
- out is combinationally independent of A/B after accept; a registered output only.

Optional Feature:
- Macro: ALU_MDU_MEXT_EN.
- Defined:
  - M ops are decoded and executed as described above.
  - The CALC state and the multiply/divide datapath are present.
- Undefined:
  - The CALC state and multiply/divide datapath are removed.
  - funct7 == 0000001 decodes as a base op with funct7[5] = 0; e.g. funct3 = 000 gives ADD.
  - Every op completes IDLE→DONE with latency 1.
  - flag never reports divide-by-zero.

Test Plan:
- Reset mid-CALC: issue DIVU A=100 B=7, assert rst at cycle 5 → out_valid stays 0; in_ready = 1 the cycle after rst; the next ADD 1+2 returns out = 3.
- ADD A=FFFFFFFF B=1 → out = 0, flag = 1, out_valid on cycle accept+1. SUB A=80000000 B=1 with sub_sign_extEn=1 → out = 7FFFFFFF, flag = 1.
- MUL A=FFFFFFFF (−1) B=3 → out = FFFFFFFD. MULHU on the same operands → out = 00000002. With MUL_BITS=1, out_valid at accept+33.
- DIV A=FFFFFFF9 (−7) B=2 → out = FFFFFFFD (−3). REM on the same operands → out = FFFFFFFF (−1). DIV A=80000000 B=FFFFFFFF → out = 80000000, latency 1.
- DIVU A=1234 B=0 → out = FFFFFFFF, flag = 1. REMU A=1234 B=0 → out = 1234. Both with latency 1.
- Backpressure: out_ready held 0 for 10 cycles after SRA A=80000000 B=4 → out stays F8000000, in_valid ignored (in_ready = 0). Release out_ready → in_ready = 1 on the next cycle.

Source files
------------

// File: rtl/alu_mdu_seq.sv
// -----------------------------------------------------------------------------
// alu_mdu_seq
//
// Handshaked execute-stage integer unit. RV32I ALU ops complete with a single
// registered cycle. When ALU_MDU_MEXT_EN is defined, RV32M multiply/divide ops
// run on an iterative datapath: a radix-2^MUL_BITS shift-add multiplier and a
// 1-bit-per-cycle restoring divider, both working on operand magnitudes with a
// sign fix-up on the final iteration.
//
// Optional feature macro: ALU_MDU_MEXT_EN
//   defined   : M ops decoded and executed (CALC state + mul/div datapath).
//   undefined : no CALC state; funct7 = 0000001 decodes as a base op with
//               funct7[5] = 0, every op completes with latency 1.
//
// Parameters:
//   XLEN      datapath width (power of 2, >= 8)
//   MUL_BITS  multiplier bits retired per CALC cycle (1, 2 or 4)
//   SHAMT_W   shift-amount width (derived from XLEN)
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake (in_ready = idle)
//   r_type, i_type, b_type, funct3, funct7, op_consShf   instruction decode
//   sub_sign_extEn  sign-extend operands into the SUB carry bit
//   A, B            operands
//   out_valid/out_ready result handshake
//   out             registered result
//   flag            carry/borrow (base ops) or divide-by-zero (M ops)
//   busy            unit is not idle
// -----------------------------------------------------------------------------
module alu_mdu_seq #(
  parameter int XLEN     = 32,
  parameter int MUL_BITS = 1,
  parameter int SHAMT_W  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            r_type,
  input  logic            i_type,
  input  logic            b_type,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic            op_consShf,
  input  logic            sub_sign_extEn,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out,
  output logic            flag,
  output logic            busy
);

`ifdef ALU_MDU_MEXT_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DONE = 2'd2
  } state_t;
`endif

  state_t            r_state;
  logic [XLEN-1:0]   r_out;
  logic              r_flag;
  logic              r_out_valid;

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state != IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign flag      = r_flag;

  // ---------------------------------------------------------------------------
  // Base ALU (combinational on the live inputs, captured on accept)
  // ---------------------------------------------------------------------------
  logic [3:0]         w_key;
  logic [SHAMT_W-1:0] w_shamt;
  logic [XLEN-1:0]    w_sra;
  logic               w_slt;
  logic               w_sltu;
  logic               w_ext_a;
  logic               w_ext_b;
  logic [XLEN:0]      w_base;   // {flag, result}

  // funct7[5] only distinguishes SUB/SRA when the encoding actually carries it;
  // for plain I-type ops it is part of the immediate and must be ignored.
  assign w_key   = (r_type | op_consShf | b_type) ? {funct3, funct7[5]} : {funct3, 1'b0};
  assign w_shamt = B[SHAMT_W-1:0];
  assign w_sra   = $signed(A) >>> w_shamt;
  assign w_slt   = $signed(A) < $signed(B);
  assign w_sltu  = A < B;
  assign w_ext_a = sub_sign_extEn & A[XLEN-1];
  assign w_ext_b = sub_sign_extEn & B[XLEN-1];

  always_comb begin
    w_base = '0;
    case (w_key)
      4'b0000: w_base = {1'b0, A} + {1'b0, B};
      4'b0001: w_base = {w_ext_a, A} - {w_ext_b, B};
      4'b0010: w_base = {1'b0, A << w_shamt};
      4'b1010: w_base = {1'b0, A >> w_shamt};
      4'b1011: w_base = {1'b0, w_sra};
      4'b0100: w_base = {{XLEN{1'b0}}, w_slt};
      4'b0110: w_base = {{XLEN{1'b0}}, w_sltu};
      4'b1000: w_base = {1'b0, A ^ B};
      4'b1100: w_base = {1'b0, A | B};
      4'b1110: w_base = {1'b0, A & B};
      default: w_base = '0;
    endcase
  end

  // Result/flag captured when an op completes on the accept edge itself.
  logic [XLEN-1:0] w_acc_res;
  logic            w_acc_flag;

`ifdef ALU_MDU_MEXT_EN
  // ---------------------------------------------------------------------------
  // M-extension decode and operand conditioning
  // ---------------------------------------------------------------------------
  localparam int              MUL_ITERS = XLEN / MUL_BITS;
  localparam int              CNT_W     = $clog2(XLEN);
  localparam logic [XLEN-1:0] SMIN      = {1'b1, {(XLEN-1){1'b0}}};

  logic            w_is_m;
  logic            w_is_div_in;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_bzero;
  logic            w_div_ovf;
  logic            w_div_byp;
  logic            w_go_calc;
  logic [XLEN-1:0] w_byp_res;
  logic            w_unused;

  assign w_unused    = i_type;
  assign w_is_m      = r_type && (funct7 == 7'b0000001);
  assign w_is_div_in = funct3[2];
  // DIV/REM are signed on both sides; MUL/MULH signed on both, MULHSU on A only.
  assign w_sgn_a     = w_is_div_in ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign w_sgn_b     = w_is_div_in ? ~funct3[0] : ~funct3[1];
  assign w_neg_a     = w_sgn_a & A[XLEN-1];
  assign w_neg_b     = w_sgn_b & B[XLEN-1];
  assign w_mag_a     = w_neg_a ? -A : A;
  assign w_mag_b     = w_neg_b ? -B : B;

  // Divide-by-zero and signed overflow have architecturally fixed answers, so
  // they skip the iterative loop entirely.
  assign w_bzero     = (B == '0);
  assign w_div_ovf   = ~funct3[0] && (A == SMIN) && (B == '1);
  assign w_div_byp   = w_is_div_in && (w_bzero || w_div_ovf);
  assign w_go_calc   = w_is_m && !w_div_byp;
  assign w_byp_res   = w_bzero ? (funct3[1] ? A : '1) : (funct3[1] ? '0 : SMIN);

  assign w_acc_res   = w_is_m ? w_byp_res : w_base[XLEN-1:0];
  assign w_acc_flag  = w_is_m ? w_bzero   : w_base[XLEN];

  // ---------------------------------------------------------------------------
  // Iterative multiply / divide datapath
  // ---------------------------------------------------------------------------
  logic [2:0]        r_func;
  logic              r_neg_q;    // product / quotient sign
  logic              r_neg_r;    // remainder sign
  logic [CNT_W-1:0]  r_cnt;
  logic [2*XLEN-1:0] r_acc;
  logic [2*XLEN-1:0] r_mcand;
  logic [XLEN-1:0]   r_mplier;
  logic [XLEN-1:0]   r_rem;
  logic [XLEN-1:0]   r_quo;
  logic [XLEN-1:0]   r_dvsr;

  logic [2*XLEN-1:0] w_pp [MUL_BITS];
  logic [2*XLEN-1:0] w_acc_next;
  logic [XLEN:0]     w_rem_sh;
  logic [XLEN+1:0]   w_diff;
  logic              w_borrow;
  logic [XLEN-1:0]   w_rem_next;
  logic [XLEN-1:0]   w_quo_next;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_fin_res;
  logic [CNT_W-1:0]  w_last;
  logic              w_calc_done;

  // One partial product per retired multiplier bit.
  genvar gi;
  generate
    for (gi = 0; gi < MUL_BITS; gi++) begin : g_pp
      assign w_pp[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
    end
  endgenerate

  always_comb begin
    w_acc_next = r_acc;
    for (int j = 0; j < MUL_BITS; j++) begin
      w_acc_next = w_acc_next + w_pp[j];
    end
  end

  // Restoring divide step: shift the next dividend bit into the partial
  // remainder and keep the subtraction only if it did not borrow.
  assign w_rem_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_dvsr};
  assign w_borrow   = w_diff[XLEN+1];
  assign w_rem_next = w_borrow ? w_rem_sh[XLEN-1:0] : w_diff[XLEN-1:0];
  assign w_quo_next = {r_quo[XLEN-2:0], ~w_borrow};

  // The final iteration's values go straight through sign fix-up into out,
  // which gives exactly one result cycle after the last iteration.
  assign w_prod = r_neg_q ? -w_acc_next : w_acc_next;

  always_comb begin
    w_fin_res = '0;
    if (r_func[2]) begin
      if (r_func[1]) w_fin_res = r_neg_r ? -w_rem_next : w_rem_next;
      else           w_fin_res = r_neg_q ? -w_quo_next : w_quo_next;
    end else begin
      if (r_func[1:0] == 2'b00) w_fin_res = w_prod[XLEN-1:0];
      else                      w_fin_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  assign w_last      = r_func[2] ? CNT_W'(XLEN - 1) : CNT_W'(MUL_ITERS - 1);
  assign w_calc_done = (r_cnt == w_last);

  // Operand registers reload every idle cycle; only the copy taken on the
  // accept edge survives into CALC, so no separate load enable is needed.
  always_ff @(posedge clk) begin
    if (r_state == IDLE) begin
      r_func   <= funct3;
      r_neg_q  <= w_neg_a ^ w_neg_b;
      r_neg_r  <= w_neg_a;
      r_acc    <= '0;
      r_mcand  <= {{XLEN{1'b0}}, w_mag_a};
      r_mplier <= w_mag_b;
      r_rem    <= '0;
      r_quo    <= w_mag_a;
      r_dvsr   <= w_mag_b;
    end else if (r_state == CALC) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << MUL_BITS;
      r_mplier <= r_mplier >> MUL_BITS;
      r_rem    <= w_rem_next;
      r_quo    <= w_quo_next;
    end
  end
`else
  logic w_unused;

  assign w_unused   = ^{i_type, funct7[6], funct7[4:0], MUL_BITS[0]};
  assign w_acc_res  = w_base[XLEN-1:0];
  assign w_acc_flag = w_base[XLEN];
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out       <= '0;
      r_flag      <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ALU_MDU_MEXT_EN
      r_cnt       <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
`ifdef ALU_MDU_MEXT_EN
            if (w_go_calc) begin
              r_state <= CALC;
              r_cnt   <= '0;
            end else
`endif
            begin
              r_out       <= w_acc_res;
              r_flag      <= w_acc_flag;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end
          end
        end
`ifdef ALU_MDU_MEXT_EN
        CALC: begin
          if (w_calc_done) begin
            r_out       <= w_fin_res;
            r_flag      <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
`endif
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
